// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 2-FF input synchroniser and one-cycle result pulses.
// Optional parity frame bit is compiled in with `define UART_RX_PARITY_EN (PARITY_ODD selects odd/even).
module uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9_600,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int DIV   = CLK_FREQ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY  = 3'd3,
`endif
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } state_t;

    // Expected parity bit for a received byte.
    function automatic logic parity_bit(input logic [7:0] b);
        return (^b) ^ (PARITY_ODD != 0);
    endfunction

    logic             sync1_q, sync2_q;
    logic             rx_s, rx_prev_q, fall_s;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_s, sample_s;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             rx_ready_q, rx_ready_d;
    logic             frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             parity_err_q, parity_err_d;
`endif

    // Two-stage synchroniser for the asynchronous serial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s     = sync2_q;
    assign fall_s   = rx_prev_q & ~rx_s;
    assign tick_s   = (div_cnt_q == DIV_LAST);
    // Data, parity and stop bits are sampled on the 16th tick after the previous sample.
    assign sample_s = tick_s & (tick_cnt_q == 4'd15);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev_q    <= 1'b1;
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            tick_cnt_q   <= 4'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            rx_ready_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_prev_q    <= rx_s;
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            rx_ready_q   <= rx_ready_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state logic: frame sequencing, bit capture and result pulses.
    always_comb begin
        state_d      = state_q;
        div_cnt_d    = tick_s ? '0 : (div_cnt_q + DIV_W'(1));
        tick_cnt_d   = tick_s ? (tick_cnt_q + 4'd1) : tick_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        rx_ready_d   = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                tick_cnt_d = 4'd0;
                if (fall_s) begin
                    state_d   = START;
                    div_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s && (tick_cnt_q == 4'd7)) begin
                    tick_cnt_d = 4'd0;
                    bit_idx_d  = 3'd0;
                    state_d    = rx_s ? IDLE : DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (sample_s) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample_s) begin
                    par_bad_d = rx_s ^ parity_bit(shift_q);
                    state_d   = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
`endif
            STOP: begin
                if (sample_s) begin
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HI;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        state_d      = IDLE;
`endif
                    end else begin
                        data_d     = shift_q;
                        rx_ready_d = 1'b1;
                        state_d    = IDLE;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            WAIT_HI: begin
                tick_cnt_d = 4'd0;
                state_d    = rx_s ? IDLE : WAIT_HI;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data      = data_q;
    assign rx_ready  = rx_ready_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=2 (32 clk per bit); parity scenario runs when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int BIT = 32;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       rx_ready, frame_err, parity_err;

    int n_cmp = 0;
    int n_mis = 0;

    int         cyc = 0;
    int         rdy_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         viol_cnt = 0;
    logic       prev_pulse = 1'b0;
    logic [7:0] rdy_data [0:63];
    int         rdy_cyc  [0:63];

    uart_rx #(
        .CLK_FREQ  (3_200_000),
        .BAUD      (100_000),
        .PARITY_ODD(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts pulses, records delivered bytes, flags overlapping or back-to-back pulses.
    always @(negedge clk) begin
        if (rx_ready) begin
            rdy_data[rdy_cnt & 63] <= data;
            rdy_cyc[rdy_cnt & 63]  <= cyc;
            rdy_cnt <= rdy_cnt + 1;
        end
        if (frame_err)  ferr_cnt <= ferr_cnt + 1;
        if (parity_err) perr_cnt <= perr_cnt + 1;
        if ((int'(rx_ready) + int'(frame_err) + int'(parity_err) > 1) ||
            (prev_pulse && (rx_ready || frame_err || parity_err)))
            viol_cnt <= viol_cnt + 1;
        prev_pulse <= rx_ready | frame_err | parity_err;
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(100);
        @(negedge clk);
        n_cmp++; if (data !== 8'h00) begin n_mis++; $display("FAIL reset_data: got %h expected 00", data); end
        n_cmp++; if (rx_ready !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
            n_mis++; $display("FAIL reset_flags: got %b%b%b expected 000", rx_ready, frame_err, parity_err); end
        n_cmp++; if (rdy_cnt + ferr_cnt + perr_cnt !== 0) begin
            n_mis++; $display("FAIL reset_pulses: got %0d expected 0", rdy_cnt + ferr_cnt + perr_cnt); end
    endtask

    task automatic test_single;
        int r0, f0;
        r0 = rdy_cnt; f0 = ferr_cnt;
        @(posedge clk); #1;
        send_frame(8'hA5, 1'b1);
        idle(20);
        n_cmp++; if (rdy_cnt - r0 !== 1) begin n_mis++; $display("FAIL a5_rdy_count: got %0d expected 1", rdy_cnt - r0); end
        n_cmp++; if (data !== 8'hA5) begin n_mis++; $display("FAIL a5_data: got %h expected a5", data); end
        n_cmp++; if (ferr_cnt - f0 !== 0) begin n_mis++; $display("FAIL a5_ferr: got %0d expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_back_to_back;
        int r0;
        r0 = rdy_cnt;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle(20);
        n_cmp++; if (rdy_cnt - r0 !== 2) begin n_mis++; $display("FAIL b2b_count: got %0d expected 2", rdy_cnt - r0); end
        n_cmp++; if (rdy_data[r0 & 63] !== 8'h3C) begin n_mis++; $display("FAIL b2b_first: got %h expected 3c", rdy_data[r0 & 63]); end
        n_cmp++; if (rdy_data[(r0 + 1) & 63] !== 8'hC3) begin n_mis++; $display("FAIL b2b_second: got %h expected c3", rdy_data[(r0 + 1) & 63]); end
        n_cmp++; if (rdy_cyc[(r0 + 1) & 63] - rdy_cyc[r0 & 63] !== FRAME_BITS * BIT) begin
            n_mis++; $display("FAIL b2b_spacing: got %0d expected %0d", rdy_cyc[(r0 + 1) & 63] - rdy_cyc[r0 & 63], FRAME_BITS * BIT); end
    endtask

    task automatic test_glitch;
        int p0;
        p0 = rdy_cnt + ferr_cnt + perr_cnt;
        rx = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        idle(64);
        n_cmp++; if (rdy_cnt + ferr_cnt + perr_cnt - p0 !== 0) begin
            n_mis++; $display("FAIL glitch_pulses: got %0d expected 0", rdy_cnt + ferr_cnt + perr_cnt - p0); end
        n_cmp++; if (data !== 8'hC3) begin n_mis++; $display("FAIL glitch_data: got %h expected c3", data); end
    endtask

    task automatic test_frame_error;
        int r0, f0;
        r0 = rdy_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (3 * BIT) @(posedge clk);
        #1;
        idle(64);
        n_cmp++; if (ferr_cnt - f0 !== 1) begin n_mis++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
        n_cmp++; if (rdy_cnt - r0 !== 0) begin n_mis++; $display("FAIL ferr_no_rdy: got %0d expected 0", rdy_cnt - r0); end
        n_cmp++; if (data !== 8'hC3) begin n_mis++; $display("FAIL ferr_data_held: got %h expected c3", data); end
        send_frame(8'h0F, 1'b1);
        idle(20);
        n_cmp++; if (rdy_cnt - r0 !== 1) begin n_mis++; $display("FAIL after_ferr_rdy: got %0d expected 1", rdy_cnt - r0); end
        n_cmp++; if (data !== 8'h0F) begin n_mis++; $display("FAIL after_ferr_data: got %h expected 0f", data); end
    endtask

    task automatic test_reset_midframe;
        int p0, r0;
        p0 = rdy_cnt + ferr_cnt + perr_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (BIT / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (data !== 8'h00) begin n_mis++; $display("FAIL midrst_data: got %h expected 00", data); end
        rst = 1'b0;
        idle(FRAME_BITS * BIT);
        n_cmp++; if (rdy_cnt + ferr_cnt + perr_cnt - p0 !== 0) begin
            n_mis++; $display("FAIL midrst_pulses: got %0d expected 0", rdy_cnt + ferr_cnt + perr_cnt - p0); end
        r0 = rdy_cnt;
        send_frame(8'h12, 1'b1);
        idle(20);
        n_cmp++; if (rdy_cnt - r0 !== 1) begin n_mis++; $display("FAIL midrst_rdy: got %0d expected 1", rdy_cnt - r0); end
        n_cmp++; if (data !== 8'h12) begin n_mis++; $display("FAIL midrst_next: got %h expected 12", data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] b, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par);
        drive_bit(1'b1);
    endtask

    task automatic test_parity;
        int r0, p0;
        r0 = rdy_cnt; p0 = perr_cnt;
        send_frame_par(8'h07, 1'b1);
        idle(20);
        n_cmp++; if (rdy_cnt - r0 !== 1) begin n_mis++; $display("FAIL par_good_rdy: got %0d expected 1", rdy_cnt - r0); end
        n_cmp++; if (data !== 8'h07) begin n_mis++; $display("FAIL par_good_data: got %h expected 07", data); end
        send_frame_par(8'h07, 1'b0);
        idle(20);
        n_cmp++; if (perr_cnt - p0 !== 1) begin n_mis++; $display("FAIL par_bad_perr: got %0d expected 1", perr_cnt - p0); end
        n_cmp++; if (rdy_cnt - r0 !== 1) begin n_mis++; $display("FAIL par_bad_rdy: got %0d expected 1", rdy_cnt - r0); end
        n_cmp++; if (data !== 8'h07) begin n_mis++; $display("FAIL par_bad_data: got %h expected 07", data); end
    endtask
`endif

    task automatic test_pulse_rules;
        n_cmp++; if (viol_cnt !== 0) begin n_mis++; $display("FAIL pulse_exclusive: got %0d violations expected 0", viol_cnt); end
`ifndef UART_RX_PARITY_EN
        n_cmp++; if (perr_cnt !== 0) begin n_mis++; $display("FAIL parity_tied: got %0d pulses expected 0", perr_cnt); end
`endif
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_error;
        test_reset_midframe;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        test_pulse_rules;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
